// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch FIFO: fetches bytes ahead of execution; an acked byte is visible the next cycle.
// Stops requesting when the in-flight request would overflow; flush drops the queue and any outstanding fetch.
module instr_prefetch_queue #(
   parameter int                 DEPTH      = 4,
   parameter int                 ADDR_W     = 16,
   parameter int                 DATA_W     = 8,
   parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [ADDR_W-1:0]        flush_addr,
   input  logic                     deq,
   output logic [DATA_W-1:0]        q_data,
   output logic                     q_valid,
   output logic [$clog2(DEPTH):0]   q_count,
   output logic [ADDR_W-1:0]        head_pc,
   output logic                     mem_req,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic                     mem_ack,
   input  logic [DATA_W-1:0]        mem_rdata
);
   localparam int                PTR_W    = $clog2(DEPTH);
   localparam int                CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

   state_t              r_state;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [ADDR_W-1:0]   r_fetch_addr;
   logic [ADDR_W-1:0]   r_head_pc;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_mem_req;

   logic                w_wr;
   logic                w_rd;
   logic [CNT_W-1:0]    w_count_nxt;
   logic [ADDR_W-1:0]   w_fetch_inc;

   // Flush overrides both the tail write and the head pop.
   assign w_wr        = (r_state == S_REQ) && mem_ack && !flush;
   assign w_rd        = deq && (r_count != '0) && !flush;
   assign w_fetch_inc = r_fetch_addr + 1'b1;

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr && !w_rd)
         w_count_nxt = r_count + 1'b1;
      else if (!w_wr && w_rd)
         w_count_nxt = r_count - 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_mem_req    <= 1'b0;
         r_mem_addr   <= RESET_ADDR;
         r_fetch_addr <= RESET_ADDR;
         r_head_pc    <= RESET_ADDR;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
      end else begin
         if (flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_head_pc    <= flush_addr;
            r_fetch_addr <= flush_addr;
         end else begin
            if (w_wr) begin
               r_wr_ptr     <= r_wr_ptr + 1'b1;
               r_fetch_addr <= w_fetch_inc;
            end
            if (w_rd) begin
               r_rd_ptr  <= r_rd_ptr + 1'b1;
               r_head_pc <= r_head_pc + 1'b1;
            end
            r_count <= w_count_nxt;
         end

         case (r_state)
            S_IDLE: begin
               if (!flush && (r_count < FULL_CNT)) begin
                  r_state    <= S_REQ;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= r_fetch_addr;
               end
            end
            S_REQ: begin
               // Keep streaming only while the next request still has a free slot.
               if (mem_ack) begin
                  if (!flush && (w_count_nxt < FULL_CNT)) begin
                     r_mem_addr <= w_fetch_inc;
                  end else begin
                     r_state   <= S_IDLE;
                     r_mem_req <= 1'b0;
                  end
               end else if (flush) begin
                  r_state <= S_DISCARD;
               end
            end
            S_DISCARD: begin
               if (mem_ack) begin
                  r_state   <= S_IDLE;
                  r_mem_req <= 1'b0;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= mem_rdata;
   end

   assign q_data   = r_mem[r_rd_ptr];
   assign q_valid  = (r_count != '0);
   assign q_count  = r_count;
   assign head_pc  = r_head_pc;
   assign mem_req  = r_mem_req;
   assign mem_addr = r_mem_addr;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: cycle table for fill/drain plus hand sequences for flush, wrap and reset.
module tb_instr_prefetch_queue;
   logic        clk;
   logic        reset;
   logic        flush;
   logic [15:0] flush_addr;
   logic        deq;
   logic [7:0]  q_data;
   logic        q_valid;
   logic [2:0]  q_count;
   logic [15:0] head_pc;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;

   instr_prefetch_queue dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .flush_addr (flush_addr),
      .deq        (deq),
      .q_data     (q_data),
      .q_valid    (q_valid),
      .q_count    (q_count),
      .head_pc    (head_pc),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } sb_t;

   typedef struct packed {
      logic        deq;
      logic        req;
      logic [15:0] addr;
      logic [2:0]  cnt;
      logic [15:0] hp;
   } vec_t;

   sb_t         sb[$];
   vec_t        tbl[14];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic        ack_en  = 1'b0;
   int          wait_cnt = 0;
   logic        m_discard = 1'b0;
   logic [15:0] m_fetch = 16'h0000;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock: drive inputs, respond to memory, update scoreboard, advance, check occupancy.
   task automatic step(input logic f, input logic [15:0] fa, input logic d);
      sb_t e;
      flush      = f;
      flush_addr = fa;
      deq        = d;
      if (ack_en && mem_req) begin
         mem_ack   = 1'b1;
         mem_rdata = mem_addr[7:0];
         wait_cnt  = 0;
      end else begin
         mem_ack   = 1'b0;
         mem_rdata = 8'h00;
         wait_cnt  = 0;
      end
      #1;
      if (f) begin
         if (mem_req && !mem_ack)
            m_discard = 1'b1;
         else if (mem_ack)
            m_discard = 1'b0;
         sb.delete();
         m_fetch = fa;
      end else begin
         if (d && sb.size() > 0) begin
            e = sb.pop_front();
            chk("q_data", {24'h0, q_data}, {24'h0, e.data});
            chk("head_pc_at_deq", {16'h0, head_pc}, {16'h0, e.addr});
         end
         if (mem_ack) begin
            if (m_discard) begin
               m_discard = 1'b0;
            end else begin
               chk("fetch_addr", {16'h0, mem_addr}, {16'h0, m_fetch});
               sb.push_back({m_fetch, m_fetch[7:0]});
               m_fetch = m_fetch + 16'h1;
            end
         end
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      chk("q_count", {29'h0, q_count}, sb.size());
      chk("q_valid", {31'h0, q_valid}, {31'h0, (sb.size() != 0)});
   endtask

   initial begin
      // deq, req, addr (only when req), count, head_pc -- sampled before each edge
      tbl[0]  = '{1'b0, 1'b0, 16'h0000, 3'd0, 16'h0000};
      tbl[1]  = '{1'b0, 1'b1, 16'h0000, 3'd0, 16'h0000};
      tbl[2]  = '{1'b0, 1'b1, 16'h0001, 3'd1, 16'h0000};
      tbl[3]  = '{1'b0, 1'b1, 16'h0002, 3'd2, 16'h0000};
      tbl[4]  = '{1'b0, 1'b1, 16'h0003, 3'd3, 16'h0000};
      tbl[5]  = '{1'b0, 1'b0, 16'h0000, 3'd4, 16'h0000};
      tbl[6]  = '{1'b0, 1'b0, 16'h0000, 3'd4, 16'h0000};
      tbl[7]  = '{1'b1, 1'b0, 16'h0000, 3'd4, 16'h0000};
      tbl[8]  = '{1'b1, 1'b0, 16'h0000, 3'd3, 16'h0001};
      tbl[9]  = '{1'b1, 1'b1, 16'h0004, 3'd2, 16'h0002};
      tbl[10] = '{1'b1, 1'b1, 16'h0005, 3'd2, 16'h0003};
      tbl[11] = '{1'b0, 1'b1, 16'h0006, 3'd2, 16'h0004};
      tbl[12] = '{1'b0, 1'b1, 16'h0007, 3'd3, 16'h0004};
      tbl[13] = '{1'b0, 1'b0, 16'h0000, 3'd4, 16'h0004};

      reset = 1'b0; flush = 1'b0; flush_addr = 16'h0; deq = 1'b0;
      mem_ack = 1'b0; mem_rdata = 8'h0;
      #12;
      chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
      chk("rst_q_valid", {31'h0, q_valid}, 32'h0);
      chk("rst_q_count", {29'h0, q_count}, 32'h0);
      chk("rst_head_pc", {16'h0, head_pc}, 32'h0);
      #5 reset = 1'b1;

      // Fill to full with single-cycle acks, then drain four and refill.
      ack_en = 1'b1;
      for (int i = 0; i < 14; i++) begin
         chk($sformatf("tbl%0d_req", i), {31'h0, mem_req}, {31'h0, tbl[i].req});
         if (tbl[i].req)
            chk($sformatf("tbl%0d_addr", i), {16'h0, mem_addr}, {16'h0, tbl[i].addr});
         chk($sformatf("tbl%0d_cnt", i), {29'h0, q_count}, {29'h0, tbl[i].cnt});
         chk($sformatf("tbl%0d_hp", i), {16'h0, head_pc}, {16'h0, tbl[i].hp});
         step(1'b0, 16'h0, tbl[i].deq);
      end

      // Flush while a fetch of 0002 is outstanding; ack arrives three cycles later.
      ack_en = 1'b0;
      step(1'b1, 16'h0000, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      ack_en = 1'b1;
      step(1'b0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      ack_en = 1'b0;
      step(1'b0, 16'h0, 1'b0);
      chk("t3_req_pending", {31'h0, mem_req}, 32'h1);
      chk("t3_addr_pending", {16'h0, mem_addr}, 32'h0002);
      step(1'b1, 16'h1234, 1'b0);
      chk("t3_discard_req", {31'h0, mem_req}, 32'h1);
      chk("t3_discard_addr", {16'h0, mem_addr}, 32'h0002);
      chk("t3_hp_flush", {16'h0, head_pc}, 32'h1234);
      step(1'b0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      chk("t3_hold_addr", {16'h0, mem_addr}, 32'h0002);
      ack_en = 1'b1;
      step(1'b0, 16'h0, 1'b0);
      chk("t3_drop_req", {31'h0, mem_req}, 32'h0);
      chk("t3_drop_cnt", {29'h0, q_count}, 32'h0);
      step(1'b0, 16'h0, 1'b0);
      chk("t3_new_req", {31'h0, mem_req}, 32'h1);
      chk("t3_new_addr", {16'h0, mem_addr}, 32'h1234);
      chk("t3_new_hp", {16'h0, head_pc}, 32'h1234);

      // Flush coinciding with an ack, then fetch across the address wrap.
      step(1'b1, 16'hFFFE, 1'b0);
      chk("t4_flush_ack_req", {31'h0, mem_req}, 32'h0);
      chk("t4_hp", {16'h0, head_pc}, 32'hFFFE);
      step(1'b0, 16'h0, 1'b0);
      chk("t4_addr0", {16'h0, mem_addr}, 32'hFFFE);
      step(1'b0, 16'h0, 1'b0);
      chk("t4_addr1", {16'h0, mem_addr}, 32'hFFFF);
      step(1'b0, 16'h0, 1'b0);
      chk("t4_addr2", {16'h0, mem_addr}, 32'h0000);
      step(1'b0, 16'h0, 1'b0);
      ack_en = 1'b0;
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      chk("t4_hp_wrap", {16'h0, head_pc}, 32'h0000);
      chk("t4_q_data", {24'h0, q_data}, 32'h00);

      // Same-cycle ack+deq, deq while empty, flush+deq and re-flush during discard.
      ack_en = 1'b1;
      step(1'b0, 16'h0, 1'b0);
      chk("t5_cnt2", {29'h0, q_count}, 32'h2);
      step(1'b0, 16'h0, 1'b1);
      chk("t5_ackdeq_cnt", {29'h0, q_count}, 32'h2);
      ack_en = 1'b0;
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      chk("t5_empty_hp", {16'h0, head_pc}, 32'h0003);
      chk("t5_empty_cnt", {29'h0, q_count}, 32'h0);
      ack_en = 1'b1;
      step(1'b0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      ack_en = 1'b0;
      step(1'b1, 16'h5000, 1'b1);
      chk("t5_fdeq_cnt", {29'h0, q_count}, 32'h0);
      chk("t5_fdeq_hp", {16'h0, head_pc}, 32'h5000);
      chk("t5_fdeq_addr", {16'h0, mem_addr}, 32'h0005);
      step(1'b1, 16'h6000, 1'b0);
      chk("t5_relatch_hp", {16'h0, head_pc}, 32'h6000);
      chk("t5_relatch_req", {31'h0, mem_req}, 32'h1);
      ack_en = 1'b1;
      step(1'b0, 16'h0, 1'b0);
      chk("t5_discard_done", {31'h0, mem_req}, 32'h0);
      step(1'b0, 16'h0, 1'b0);
      chk("t5_relatch_addr", {16'h0, mem_addr}, 32'h6000);

      // Asynchronous reset between edges while a request is outstanding.
      ack_en = 1'b0;
      #3 reset = 1'b0;
      #1;
      chk("t6_req", {31'h0, mem_req}, 32'h0);
      chk("t6_cnt", {29'h0, q_count}, 32'h0);
      chk("t6_hp", {16'h0, head_pc}, 32'h0);
      sb.delete();
      m_fetch = 16'h0000;
      m_discard = 1'b0;
      #2 reset = 1'b1;
      step(1'b0, 16'h0, 1'b0);
      chk("t6_resume_req", {31'h0, mem_req}, 32'h1);
      chk("t6_resume_addr", {16'h0, mem_addr}, 32'h0000);
      ack_en = 1'b1;
      step(1'b0, 16'h0, 1'b0);
      chk("t6_next_addr", {16'h0, mem_addr}, 32'h0001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
